// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and helpers shared by the button front end.
//   SYNC_STAGES_MIN : shortest synchroniser chain that still gives
//                     metastability protection.
//   cnt_width()     : debounce counter width, never below 1 bit.
package pwm_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel -- synchroniser chain, debounce counter,
// debounced level register and single-cycle edge pulses.
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   din        raw asynchronous input
//   sample_en  debounce sample strobe
//   level      debounced level, active-high
//   rise/fall  one-cycle pulses coinciding with a level change
module debounce_ch
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int DB_CYCLES   = 16,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > 8) begin : g_bad_sync
    $error("debounce_ch: SYNC_STAGES out of range 2..8");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("debounce_ch: DB_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_bit;

  // Normalise polarity right after the chain so the debouncer is always
  // active-high.
  assign sync_bit = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Load the idle raw value so the first post-reset sample matches level.
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sample_en) begin
        if (sync_bit == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // Cleared on acceptance, so the counter never wraps.
          level <= sync_bit;
          cnt   <= '0;
          rise  <= sync_bit;
          fall  <= ~sync_bit;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/btn_sync_debounce.sv
// btn_sync_debounce: multi-channel synchronise-and-debounce front end for
// push-buttons and switches feeding the PWM control logic.
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   din        raw asynchronous inputs, one bit per channel
//   sample_en  debounce sample strobe (tie high to sample every clock)
//   level      debounced level per channel, active-high
//   rise/fall  one-cycle pulses per channel on level 0->1 / 1->0
module btn_sync_debounce
  import pwm_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 3,
  parameter int DB_CYCLES   = 16,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  input  logic            sample_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din[i]),
      .sample_en (sample_en),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule

// File: tb/tb_btn_sync_debounce.sv
module tb_btn_sync_debounce;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b1;
  logic [N-1:0] din = '0;
  logic [N-1:0] din_al;
  logic [N-1:0] level0, rise0, fall0;
  logic [N-1:0] level1, rise1, fall1;

  always #5 clk = ~clk;

  // Second instance is pressed-low: it sees the same logical stimulus inverted,
  // so both must produce identical outputs.
  assign din_al = ~din;

  btn_sync_debounce #(.N_CH(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en),
    .level(level0), .rise(rise0), .fall(fall0));

  btn_sync_debounce #(.N_CH(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .din(din_al), .sample_en(sample_en),
    .level(level1), .rise(rise1), .fall(fall1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw history delayed by SS edges, plus a history of
  // strobed samples. A channel flips when its last DB strobed samples all
  // differ from the current level.
  logic [N-1:0] rawq[$];
  logic [N-1:0] sampq[$];
  logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0;

  task automatic model_edge(input logic r, input logic [N-1:0] d, input logic en);
    logic [N-1:0] s;
    bit all_diff;
    if (!r) begin
      rawq.delete();
      for (int k = 0; k < SS; k++) rawq.push_back('0);
      sampq.delete();
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
    end else begin
      s = rawq[rawq.size() - SS];
      rawq.push_back(d);
      if (rawq.size() > 16) void'(rawq.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (en) begin
        sampq.push_back(s);
        if (sampq.size() > 16) void'(sampq.pop_front());
        for (int i = 0; i < N; i++) begin
          if (sampq.size() >= DB) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++)
              if (sampq[sampq.size()-1-k][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
              m_level[i] = ~m_level[i];
              if (m_level[i]) m_rise[i] = 1'b1;
              else            m_fall[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] d, input logic en);
    @(negedge clk);
    rst_n     = r;
    din       = d;
    sample_en = en;
    model_edge(r, d, en);
    @(posedge clk);
    #1;
    check("level_ah", level0, m_level);
    check("rise_ah",  rise0,  m_rise);
    check("fall_ah",  fall0,  m_fall);
    check("level_al", level1, m_level);
    check("rise_al",  rise1,  m_rise);
    check("fall_al",  fall1,  m_fall);
  endtask

  int rise_edge;
  int nrise;
  logic [N-1:0] d;
  logic [8:0] bounce;

  initial begin
    // Reset, then idle for 10 cycles.
    for (int e = 0; e < 3; e++) step(1'b0, 2'b00, 1'b1);
    for (int e = 0; e < 10; e++) step(1'b1, 2'b00, 1'b1);

    // Clean step on channel 0: rise exactly after edge SS+DB.
    rise_edge = -1;
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, 2'b01, 1'b1);
      if (rise0[0] && rise_edge < 0) rise_edge = e;
    end
    check("step_latency", rise_edge, SS + DB);

    // Short pulse on channel 1 is rejected, 4-sample pulse is accepted.
    nrise = 0;
    for (int e = 0; e < 3; e++) begin step(1'b1, 2'b11, 1'b1); nrise += rise0[1]; end
    for (int e = 0; e < 8; e++) begin step(1'b1, 2'b01, 1'b1); nrise += rise0[1]; end
    check("glitch_no_rise", nrise, 0);
    for (int e = 0; e < 4; e++)  step(1'b1, 2'b11, 1'b1);
    for (int e = 0; e < 12; e++) step(1'b1, 2'b01, 1'b1);

    // Bounce on channel 0 going low, then going high: one pulse each way.
    bounce = 9'b111101101;
    for (int e = 0; e < 9; e++) step(1'b1, {1'b0, ~bounce[e]}, 1'b1);
    for (int e = 0; e < 8; e++) step(1'b1, 2'b00, 1'b1);
    nrise = 0;
    for (int e = 0; e < 9; e++) begin step(1'b1, {1'b0, bounce[e]}, 1'b1); nrise += rise0[0]; end
    for (int e = 0; e < 8; e++) begin step(1'b1, 2'b01, 1'b1); nrise += rise0[0]; end
    check("bounce_one_rise", nrise, 1);

    // Strobe every 4th clock with a clean step on both channels.
    for (int e = 0; e < 40; e++) step(1'b1, 2'b10, (e % 4) == 0);

    // Reset in the middle of a debounce.
    for (int e = 0; e < 12; e++) step(1'b1, 2'b00, 1'b1);
    for (int e = 0; e < 4; e++)  step(1'b1, 2'b01, 1'b1);
    step(1'b0, 2'b01, 1'b1);
    for (int e = 0; e < 10; e++) step(1'b1, 2'b01, 1'b1);

    // Randomised traffic.
    d = 2'b00;
    for (int e = 0; e < 3000; e++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
      step($urandom_range(0, 199) != 0, d, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
